// File: rtl/ap_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : ap_result_reader
// Purpose  : Read-back engine for the associative processor. On a start
//            pulse (or an ap_state_irq rising edge when auto_en=1) it reads
//            num_words consecutive cells of one CAM column through the AP
//            host read port. It buffers the returned words in a small
//            credit-controlled FIFO and streams them out on valid/ready.
// Ports    : CLK100MHZ, rst_n (sync, active-low)
//            start, auto_en, ap_state_irq        - drain triggers
//            first_addr, num_words, rd_col,
//            rd_internal_col                     - drain parameters
//            ap_addr, ap_sel_col, ap_sel_internal_col, ap_read_en,
//            ap_write_en, ap_mode, ap_data_out   - AP host read port
//            m_valid, m_ready, m_data, m_addr,
//            m_last                              - result stream
//            busy, done                          - status
// Revision : 1.0 - initial release
// ============================================================================
module ap_result_reader #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = 9,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic                 ap_state_irq,
  input  logic [ADDR_W-1:0]    first_addr,
  input  logic [ADDR_W:0]      num_words,
  input  logic [1:0]           rd_col,
  input  logic                 rd_internal_col,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic                 ap_read_en,
  output logic                 ap_write_en,
  output logic                 ap_mode,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_SIZE-1:0] m_data,
  output logic [ADDR_W-1:0]    m_addr,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // One spare bit so occupancy, in-flight count and credit never overflow.
  localparam int CNT_W = PTR_W + 2;
  localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST_ADR = ADDR_W'(CELL_QUANT - 1);
  localparam logic [ADDR_W:0]   C_ONE_WORD = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                irq_q, irq_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [1:0]          col_q, col_d;
  logic                int_col_q, int_col_d;
  logic [1:0]          sel_col_q, sel_col_d;
  logic                sel_int_q, sel_int_d;

  // Read-latency pipeline: tags each issued read with its address and last flag
  logic                pipe_vld_q  [RD_LAT];
  logic                pipe_vld_d  [RD_LAT];
  logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];
  logic [ADDR_W-1:0]   pipe_addr_d [RD_LAT];
  logic                pipe_last_q [RD_LAT];
  logic                pipe_last_d [RD_LAT];

  // Output FIFO
  logic [WORD_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]    fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    fifo_addr_d [FIFO_DEPTH];
  logic                 fifo_last_q [FIFO_DEPTH];
  logic                 fifo_last_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     occ_q, occ_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             trigger;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;
  logic [CNT_W-1:0] credit;

  always_comb begin
    inflight_q = '0;
    inflight_d = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      inflight_q = inflight_q + CNT_W'(pipe_vld_q[k]);
      inflight_d = inflight_d + CNT_W'(pipe_vld_d[k]);
    end
  end

  // Reads already issued still own a FIFO slot, so they are charged
  // against credit before their data arrives.
  assign credit  = C_DEPTH - occ_q - inflight_q;
  assign trigger = start | (auto_en & ap_state_irq & ~irq_q);
  assign issue   = (state_q == S_ISSUE) && (remain_q != '0) && (credit != '0);
  assign push    = pipe_vld_q[RD_LAT-1];
  assign pop     = m_valid & m_ready;

  // --------------------------------------------------------------------------
  // Read pipeline and FIFO next-state
  // --------------------------------------------------------------------------
  always_comb begin
    pipe_vld_d  = pipe_vld_q;
    pipe_addr_d = pipe_addr_q;
    pipe_last_d = pipe_last_q;
    pipe_vld_d[0]  = issue;
    pipe_addr_d[0] = addr_q;
    pipe_last_d[0] = (remain_q == C_ONE_WORD);
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_addr_d[k] = pipe_addr_q[k-1];
      pipe_last_d[k] = pipe_last_q[k-1];
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = ap_data_out;
      fifo_addr_d[wr_ptr_q] = pipe_addr_q[RD_LAT-1];
      fifo_last_d[wr_ptr_q] = pipe_last_q[RD_LAT-1];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    irq_d     = ap_state_irq;
    addr_d    = addr_q;
    remain_d  = remain_q;
    col_d     = col_q;
    int_col_d = int_col_q;
    sel_col_d = sel_col_q;
    sel_int_d = sel_int_q;

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          addr_d    = first_addr;
          remain_d  = num_words;
          col_d     = rd_col;
          int_col_d = rd_internal_col;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        sel_col_d = col_q;
        sel_int_d = int_col_q;
        state_d   = (remain_q == '0) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d   = (addr_q == C_LAST_ADR) ? '0 : addr_q + ADDR_W'(1);
          remain_d = remain_q - C_ONE_WORD;
          if (remain_q == C_ONE_WORD) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Look at next-cycle counts so done lands right after the final pop.
        if ((occ_d == '0) && (inflight_d == '0)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      irq_q     <= 1'b0;
      addr_q    <= '0;
      remain_q  <= '0;
      col_q     <= '0;
      int_col_q <= 1'b0;
      sel_col_q <= '0;
      sel_int_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_addr_q[k] <= '0;
        pipe_last_q[k] <= 1'b0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_data_q[k] <= '0;
        fifo_addr_q[k] <= '0;
        fifo_last_q[k] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      col_q       <= col_d;
      int_col_q   <= int_col_d;
      sel_col_q   <= sel_col_d;
      sel_int_q   <= sel_int_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_last_q <= pipe_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ap_addr             = addr_q;
  assign ap_sel_col          = sel_col_q;
  assign ap_sel_internal_col = sel_int_q;
  assign ap_read_en          = issue;
  assign ap_write_en         = 1'b0;
  assign ap_mode             = 1'b0;   // memory mode; the reader never computes
  assign m_valid             = (occ_q != '0);
  assign m_data              = fifo_data_q[rd_ptr_q];
  assign m_addr              = fifo_addr_q[rd_ptr_q];
  assign m_last              = fifo_last_q[rd_ptr_q];
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_ap_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_result_reader
// Purpose  : Scoreboard bench for ap_result_reader. Stimulus tasks push the
//            expected stream into a queue. A negedge monitor pops and compares
//            every handshaken word and also tracks reads, done pulses and
//            outstanding reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ap_result_reader;

  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [7:0] d;
    logic [8:0] a;
    logic       l;
  } exp_t;

  logic       CLK100MHZ = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       ap_state_irq = 1'b0;
  logic [8:0] first_addr = '0;
  logic [9:0] num_words = '0;
  logic [1:0] rd_col = '0;
  logic       rd_internal_col = 1'b0;
  logic [7:0] ap_data_out = '0;
  logic       m_ready = 1'b1;
  logic [8:0] ap_addr;
  logic [1:0] ap_sel_col;
  logic       ap_sel_internal_col, ap_read_en, ap_write_en, ap_mode;
  logic       m_valid, m_last, busy, done;
  logic [7:0] m_data;
  logic [8:0] m_addr;

  ap_result_reader #(
    .WORD_SIZE(8), .CELL_QUANT(512), .ADDR_W(9), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .rst_n(rst_n), .start(start), .auto_en(auto_en),
    .ap_state_irq(ap_state_irq), .first_addr(first_addr), .num_words(num_words),
    .rd_col(rd_col), .rd_internal_col(rd_internal_col), .ap_addr(ap_addr),
    .ap_sel_col(ap_sel_col), .ap_sel_internal_col(ap_sel_internal_col),
    .ap_read_en(ap_read_en), .ap_write_en(ap_write_en), .ap_mode(ap_mode),
    .ap_data_out(ap_data_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // AP column memory model, one-cycle read latency
  logic [7:0] mem [0:2][0:511];
  always @(posedge CLK100MHZ) begin
    if (ap_read_en) ap_data_out <= mem[ap_sel_col][ap_addr];
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rd_cnt = 0, done_cnt = 0, hs_cnt = 0;
  int   done_cyc = -1, last_hs_cyc = -100;
  int   outst = 0, max_outst = 0;
  bit   bp_mode = 1'b0;
  int   bp_cnt = 0;
  exp_t q[$];
  bit   prev_stall = 1'b0;
  logic [7:0] h_d;
  logic [8:0] h_a;
  logic       h_l;

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Consumer ready: constant 1, or toggling every 3 cycles under backpressure
  initial begin
    forever begin
      @(posedge CLK100MHZ);
      #1;
      if (bp_mode) begin
        bp_cnt++;
        if (bp_cnt >= 3) begin
          bp_cnt  = 0;
          m_ready = ~m_ready;
        end
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge CLK100MHZ) begin
    int   now;
    exp_t e;
    if (ap_read_en) rd_cnt++;
    now = outst + (ap_read_en ? 1 : 0);
    if (now > max_outst) max_outst = now;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall) begin
      n_vec++;
      if (!m_valid || m_data !== h_d || m_addr !== h_a || m_last !== h_l) begin
        n_err++;
        $display("FAIL stall_hold: got v=%0d d=%0d a=%0d l=%0d, expected v=1 d=%0d a=%0d l=%0d",
                 m_valid, m_data, m_addr, m_last, h_d, h_a, h_l);
      end
    end
    prev_stall = m_valid && !m_ready;
    h_d = m_data;
    h_a = m_addr;
    h_l = m_last;
    if (m_valid && m_ready) begin
      hs_cnt++;
      now--;
      if (m_last) last_hs_cyc = cyc;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got d=%0d a=%0d, expected no word", m_data, m_addr);
      end else begin
        e = q.pop_front();
        if (m_data !== e.d || m_addr !== e.a || m_last !== e.l) begin
          n_err++;
          $display("FAIL stream_word: got d=%0d a=%0d l=%0d, expected d=%0d a=%0d l=%0d",
                   m_data, m_addr, m_last, e.d, e.a, e.l);
        end
      end
    end
    outst = now;
  end

  task automatic clear_counts();
    rd_cnt = 0; done_cnt = 0; hs_cnt = 0;
    done_cyc = -1; last_hs_cyc = -100;
    outst = 0; max_outst = 0;
  endtask

  task automatic push_expected(input int fa, input int n, input int col);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (fa + i) % 512;
      q.push_back('{mem[col][a], 9'(a), (i == n - 1)});
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, int'(|{ap_addr, ap_sel_col, ap_sel_internal_col, ap_read_en, ap_write_en,
                     ap_mode, m_valid, m_data, m_addr, m_last, busy, done}), 0);
  endtask

  task automatic run(input int fa, input int n, input int col, input bit use_irq,
                     input bit mid_start);
    int s_cyc;
    @(posedge CLK100MHZ);
    #1;
    clear_counts();
    push_expected(fa, n, col);
    first_addr = 9'(fa);
    num_words  = 10'(n);
    rd_col     = 2'(col);
    if (use_irq) ap_state_irq = 1'b1;
    else         start = 1'b1;
    s_cyc = cyc;
    @(posedge CLK100MHZ);
    #1;
    start = 1'b0;
    if (mid_start) begin
      for (int k = 0; k < 2000 && hs_cnt < 100; k++) @(posedge CLK100MHZ);
      #1;
      first_addr = 9'd7;
      num_words  = 10'd3;
      start      = 1'b1;
      @(posedge CLK100MHZ);
      #1;
      start = 1'b0;
    end
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge CLK100MHZ);
    if (done_cnt == 0) $display("FAIL drain_timeout: got no done, expected done within 4000 cycles");
    @(posedge CLK100MHZ);
    #1;
    chk("busy_after_done", int'(busy), 0);
    chk("done_count", done_cnt, 1);
    chk("read_count", rd_cnt, n);
    chk("word_count", hs_cnt, n);
    chk("queue_left", q.size(), 0);
    chk("max_outstanding_ok", int'(max_outst <= FIFO_DEPTH), 1);
    if (n == 0) begin
      chk("done_latency_empty", done_cyc - s_cyc, 2);
    end else begin
      chk("done_after_last", done_cyc - last_hs_cyc, 1);
      if (!bp_mode) chk("done_latency", done_cyc - s_cyc, n + RD_LAT + 3);
    end
    q.delete();
  endtask

  initial begin
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 512; i++)
        mem[c][i] = 8'((i * 5 + c * 17 + 1) & 255);
    mem[2][0] = 8'd3;
    mem[2][1] = 8'd7;
    mem[2][2] = 8'd11;
    mem[2][3] = 8'd250;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    #1;
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;

    // Basic drain of column C: 3,7,11,250
    run(0, 4, 2, 1'b0, 1'b0);
    // Address wrap 510,511,0,1
    run(510, 4, 1, 1'b0, 1'b0);
    // Backpressure
    bp_mode = 1'b1;
    run(20, 16, 0, 1'b0, 1'b0);
    bp_mode = 1'b0;
    // Empty drain
    run(5, 0, 0, 1'b0, 1'b0);

    // Auto trigger: column C holds A(=1) + B(=i%3)
    for (int i = 0; i < 512; i++) mem[2][i] = 8'(1 + (i % 3));
    auto_en = 1'b1;
    run(0, 512, 2, 1'b1, 1'b1);
    ap_state_irq = 1'b0;
    auto_en      = 1'b0;

    // Reset in the middle of a drain
    @(posedge CLK100MHZ);
    #1;
    clear_counts();
    push_expected(100, 20, 0);
    first_addr = 9'd100;
    num_words  = 10'd20;
    rd_col     = 2'd0;
    start      = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    start = 1'b0;
    for (int k = 0; k < 200 && hs_cnt < 5; k++) @(posedge CLK100MHZ);
    #1;
    chk("words_before_reset", int'(hs_cnt >= 5), 1);
    rst_n = 1'b0;
    @(posedge CLK100MHZ);
    #1;
    rst_n = 1'b1;
    check_reset_outputs("midreset_outputs");
    q.delete();
    repeat (30) @(posedge CLK100MHZ);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    run(300, 6, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
